// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//
// Registered memory-access pipeline stage sitting between EX and WB.
// Memory ops are issued on a request/acknowledge bus (MREQ/MACK) that may
// insert any number of wait states. Upstream is stalled while an access is
// in flight. The stage steers store data onto byte lanes and aligns and
// extends load data. It then presents a single-cycle registered result
// to WB. Non-memory results pass through with one cycle of latency.
//
// Accesses are truncated to natural alignment. An access that waits TIMEOUT
// cycles beyond its first request cycle without MACK is aborted with wb_err.
//
// Optional feature (macro MEM_MISALIGN_TRAP_EN):
//   When defined, a misaligned memory op is never issued. Instead it
//   produces an error result whose wb_data carries the faulting address.
//
// Parameters:
//   DATA_W   data bus width (32 or 64)
//   ADDR_W   byte address width
//   TIMEOUT  extra wait cycles allowed for MACK before abort (>= 1)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_*                 EX result / memory op (held by upstream on stall_o)
//   stall_o              upstream must hold in_*
//   MREQ, WRITE, SIZE    memory request, store flag, registered size
//   BE, DAD, DDT_O       byte enables, lane-aligned address, steered data
//   DDT_I, MACK          load data, one-cycle acknowledge
//   wb_valid, wb_data,   WB result pulse, data, destination,
//   wb_rd, wb_regwrite,  write enable and abort flag
//   wb_err
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_mreq,
    input  logic                in_write,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [DATA_W-1:0]   in_bypass,
    input  logic [4:0]          in_rd,
    input  logic                in_regwrite,
    output logic                stall_o,
    output logic                MREQ,
    output logic                WRITE,
    output logic [1:0]          SIZE,
    output logic [DATA_W/8-1:0] BE,
    output logic [ADDR_W-1:0]   DAD,
    output logic [DATA_W-1:0]   DDT_O,
    input  logic [DATA_W-1:0]   DDT_I,
    input  logic                MACK,
    output logic                wb_valid,
    output logic [DATA_W-1:0]   wb_data,
    output logic [4:0]          wb_rd,
    output logic                wb_regwrite,
    output logic                wb_err
);

    localparam int LB = $clog2(DATA_W/8);
    localparam int NB = DATA_W/8;
    localparam int CW = $clog2(TIMEOUT+1);
    localparam int IW = $clog2(DATA_W);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;

    // Context of the access in flight, needed when the load data returns.
    logic [LB-1:0]   acc_off;
    logic [1:0]      acc_size;
    logic            acc_unsigned;
    logic [4:0]      acc_rd;
    logic            acc_regwrite;

    logic [1:0]      req_size;
    logic [LB-1:0]   req_off;
    logic [NB-1:0]   req_be;
    logic            trap;

    logic [DATA_W-1:0] load_shifted;
    logic [DATA_W-1:0] load_mask;
    logic [6:0]        load_bits;
    logic              load_sign;
    logic [DATA_W-1:0] load_data;

    // Request decode. A dword request on a 32-bit bus behaves as a word.
    // The lane offset drops the address bits below the access size, which
    // truncates misaligned accesses to natural alignment.
    always_comb begin
        req_size = in_size;
        if (DATA_W == 32 && in_size == 2'b11) begin
            req_size = 2'b10;
        end
        req_off = in_addr[LB-1:0] & ~LB'((1 << req_size) - 1);
        req_be  = NB'(((1 << (1 << req_size)) - 1) << req_off);
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = in_mreq && |(in_addr[LB-1:0] & LB'((1 << req_size) - 1));
`else
    assign trap = 1'b0;
`endif

    // Load alignment: bring the addressed lane down to bit 0, then keep
    // only the accessed bits and fill the rest with zero or the sign bit.
    // For a full-width access the mask is all ones so data passes as is.
    always_comb begin
        load_shifted = DDT_I >> {acc_off, 3'b000};
        load_bits    = 7'd8 << acc_size;
        load_mask    = ~({DATA_W{1'b1}} << load_bits);
        load_sign    = load_shifted[IW'(load_bits - 7'd1)];
        if (!acc_unsigned && load_sign) begin
            load_data = load_shifted | ~load_mask;
        end else begin
            load_data = load_shifted & load_mask;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: an issued memory op moves to ACCESS, which ends on MACK or
    // once the wait counter has reached TIMEOUT. MACK takes priority.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && in_mreq && !trap) state_next = ACCESS;
            ACCESS:  if (MACK || count == CW'(TIMEOUT)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall_o = (state == ACCESS);

    // Datapath: memory bus registers, access context, wait counter and the
    // WB result. Result flags pulse for one cycle; wb_data/wb_rd hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MREQ         <= 1'b0;
            WRITE        <= 1'b0;
            SIZE         <= 2'b00;
            BE           <= '0;
            DAD          <= '0;
            DDT_O        <= '0;
            count        <= '0;
            acc_off      <= '0;
            acc_size     <= 2'b00;
            acc_unsigned <= 1'b0;
            acc_rd       <= 5'd0;
            acc_regwrite <= 1'b0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= 5'd0;
            wb_regwrite  <= 1'b0;
            wb_err       <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!in_mreq) begin
                            wb_valid    <= 1'b1;
                            wb_data     <= in_bypass;
                            wb_rd       <= in_rd;
                            wb_regwrite <= in_regwrite;
                        end else if (trap) begin
                            wb_valid    <= 1'b1;
                            wb_err      <= 1'b1;
                            wb_data     <= DATA_W'(in_addr);
                            wb_rd       <= in_rd;
                        end else begin
                            MREQ         <= 1'b1;
                            WRITE        <= in_write;
                            SIZE         <= in_size;
                            BE           <= req_be;
                            DAD          <= {in_addr[ADDR_W-1:LB], LB'(0)};
                            DDT_O        <= in_wdata << {req_off, 3'b000};
                            count        <= '0;
                            acc_off      <= req_off;
                            acc_size     <= req_size;
                            acc_unsigned <= in_unsigned;
                            acc_rd       <= in_rd;
                            acc_regwrite <= in_regwrite;
                        end
                    end
                end
                ACCESS: begin
                    if (MACK) begin
                        MREQ     <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= acc_rd;
                        if (!WRITE) begin
                            wb_data     <= load_data;
                            wb_regwrite <= acc_regwrite;
                        end
                    end else if (count == CW'(TIMEOUT)) begin
                        MREQ     <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_rd    <= acc_rd;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Self-checking bench for mem_stage_ctrl (DATA_W=32, ADDR_W=32, TIMEOUT=4).
// Each op is described as a transaction with a MACK delay. Expected bus
// values and results come from byte-level reference functions. Timing comes
// from the op's delay (delay > TIMEOUT means MACK never arrives).
// Builds with or without MEM_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;
    localparam int NB = DW/8;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_mreq, in_write, in_unsigned, in_regwrite;
    logic [1:0]    in_size;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata, in_bypass;
    logic [4:0]    in_rd;
    logic          stall_o, MREQ, WRITE, MACK;
    logic [1:0]    SIZE;
    logic [NB-1:0] BE;
    logic [AW-1:0] DAD;
    logic [DW-1:0] DDT_O, DDT_I;
    logic          wb_valid, wb_regwrite, wb_err;
    logic [DW-1:0] wb_data;
    logic [4:0]    wb_rd;

    int vectors     = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_wb_data = '0;

    typedef struct {
        bit        mreq;
        bit        write;
        bit [1:0]  size;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] bypass;
        bit [4:0]  rd;
        bit        regwrite;
        int        delay;
        bit [31:0] rdata;
    } op_t;

    mem_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_mreq(in_mreq), .in_write(in_write),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_bypass(in_bypass), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .stall_o(stall_o),
        .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .BE(BE), .DAD(DAD),
        .DDT_O(DDT_O), .DDT_I(DDT_I), .MACK(MACK),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports each miscompare.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model helpers, expressed per byte.
    function automatic int effBytes(input bit [1:0] size);
        return (size == 2'b11) ? 4 : (1 << size);
    endfunction

    function automatic int laneOff(input bit [31:0] addr, input int bytes);
        return ((int'(addr % NB)) / bytes) * bytes;
    endfunction

    function automatic bit [NB-1:0] modelBe(input int off, input int bytes);
        bit [NB-1:0] be = '0;
        for (int j = 0; j < NB; j++) be[j] = (j >= off) && (j < off + bytes);
        return be;
    endfunction

    function automatic bit [31:0] modelSteer(input bit [31:0] wdata, input int off);
        bit [31:0] r = '0;
        for (int j = off; j < NB; j++) r[j*8 +: 8] = wdata[(j-off)*8 +: 8];
        return r;
    endfunction

    function automatic bit [31:0] modelLoad(input bit [31:0] rdata, input int off,
                                            input int bytes, input bit uns);
        longint v = 0;
        for (int j = 0; j < bytes; j++) v += longint'(rdata[(off+j)*8 +: 8]) << (8*j);
        if (!uns && v >= (longint'(1) << (8*bytes - 1))) v -= longint'(1) << (8*bytes);
        return 32'(v);
    endfunction

    task automatic driveOp(input op_t op, input bit valid);
        in_valid    = valid;
        in_mreq     = op.mreq;
        in_write    = op.write;
        in_size     = op.size;
        in_unsigned = op.uns;
        in_addr     = op.addr;
        in_wdata    = op.wdata;
        in_bypass   = op.bypass;
        in_rd       = op.rd;
        in_regwrite = op.regwrite;
    endtask

    // Presents one op at a negedge in IDLE and follows it to its WB result.
    // Returns at the negedge of the result cycle, ready for the next op.
    task automatic applyStimulus(input op_t op);
        int bytes, off, k;
        bit trap, tmo;
        bytes = effBytes(op.size);
        off   = laneOff(op.addr, bytes);
        trap  = TRAP_EN && op.mreq && ((op.addr % bytes) != 0);
        checkOutput("stall_idle", stall_o, 0);
        driveOp(op, 1'b1);
        @(posedge clk);
        if (!op.mreq || trap) begin
            @(negedge clk);
            exp_wb_data = trap ? op.addr : op.bypass;
            checkOutput("mreq_low", MREQ, 0);
            checkOutput("wb_valid", wb_valid, 1);
            checkOutput("wb_err", wb_err, trap);
            checkOutput("wb_regwrite", wb_regwrite, trap ? 1'b0 : op.regwrite);
            checkOutput("wb_data", wb_data, exp_wb_data);
            checkOutput("wb_rd", wb_rd, op.rd);
        end else begin
            tmo = op.delay > TO;
            k   = tmo ? TO + 1 : op.delay + 1;
            for (int i = 1; i <= k; i++) begin
                @(negedge clk);
                checkOutput("mreq_high", MREQ, 1);
                checkOutput("stall_busy", stall_o, 1);
                checkOutput("wb_valid_busy", wb_valid, 0);
                if (i == 1) begin
                    checkOutput("write", WRITE, op.write);
                    checkOutput("size", SIZE, op.size);
                    checkOutput("be", BE, modelBe(off, bytes));
                    checkOutput("dad", DAD, op.addr - (op.addr % NB));
                    checkOutput("ddt_o", DDT_O, modelSteer(op.wdata, off));
                end
                MACK  = !tmo && (i == op.delay + 1);
                DDT_I = MACK ? op.rdata : $urandom;
                @(posedge clk);
                #1 MACK = 1'b0;
            end
            @(negedge clk);
            if (!tmo && !op.write) exp_wb_data = modelLoad(op.rdata, off, bytes, op.uns);
            checkOutput("mreq_drop", MREQ, 0);
            checkOutput("stall_done", stall_o, 0);
            checkOutput("wb_valid", wb_valid, 1);
            checkOutput("wb_err", wb_err, tmo);
            checkOutput("wb_regwrite", wb_regwrite, (!tmo && !op.write) ? op.regwrite : 1'b0);
            checkOutput("wb_data", wb_data, exp_wb_data);
            checkOutput("wb_rd", wb_rd, op.rd);
        end
    endtask

    task automatic idleCycle();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_wb_valid", wb_valid, 0);
        checkOutput("idle_mreq", MREQ, 0);
        checkOutput("idle_wb_data", wb_data, exp_wb_data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        op_t op;
        rst_n = 1'b0;
        MACK  = 1'b0;
        DDT_I = '0;
        op    = '{default: 0};
        driveOp(op, 1'b0);
        #1;
        checkOutput("rst_mreq", MREQ, 0);
        checkOutput("rst_be", BE, 0);
        checkOutput("rst_dad", DAD, 0);
        checkOutput("rst_ddt_o", DDT_O, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_wb_err", wb_err, 0);
        checkOutput("rst_stall", stall_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of an access drops MREQ without a clock edge.
        op = '{mreq:1, size:2'b10, addr:32'h40, rd:5'd3, regwrite:1, delay:99, default:0};
        driveOp(op, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("pre_rst_mreq", MREQ, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_mreq", MREQ, 0);
        checkOutput("async_rst_stall", stall_o, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idleCycle();

        // Signed byte load from the top lane, MACK 3 cycles after MREQ.
        op = '{mreq:1, size:2'b00, addr:32'h1003, rdata:32'h80FF_FF11,
               rd:5'd7, regwrite:1, delay:3, default:0};
        applyStimulus(op);
        // Non-memory op taken right after the load result.
        op = '{bypass:32'h1234, rd:5'd9, regwrite:1, default:0};
        applyStimulus(op);
        // Half store to the upper half, immediate MACK.
        op = '{mreq:1, write:1, size:2'b01, addr:32'h2002, wdata:32'h0000_BEEF,
               rd:5'd2, regwrite:1, delay:0, default:0};
        applyStimulus(op);
        // MACK never arrives: abort after TIMEOUT+1 request cycles.
        op = '{mreq:1, size:2'b10, addr:32'h500, rd:5'd4, regwrite:1, delay:99, default:0};
        applyStimulus(op);
        // Misaligned word load: trapped or truncated depending on the build.
        op = '{mreq:1, size:2'b10, addr:32'h3001, rdata:32'hCAFE_F00D,
               rd:5'd6, regwrite:1, delay:1, default:0};
        applyStimulus(op);
        idleCycle();

        // Randomized ops, occasionally separated by idle cycles.
        for (int n = 0; n < 80; n++) begin
            op.mreq     = ($urandom_range(0, 3) != 0);
            op.write    = $urandom_range(0, 1);
            op.size     = 2'($urandom_range(0, 3));
            op.uns      = $urandom_range(0, 1);
            op.addr     = $urandom;
            op.wdata    = $urandom;
            op.bypass   = $urandom;
            op.rd       = 5'($urandom_range(0, 31));
            op.regwrite = $urandom_range(0, 1);
            op.delay    = $urandom_range(0, TO + 2);
            op.rdata    = $urandom;
            applyStimulus(op);
            if ($urandom_range(0, 4) == 0) idleCycle();
        end
        idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Registered memory-access pipeline stage between EX and WB.
- Issues requests to data memory over a request/acknowledge bus with variable wait states, and stalls upstream while an access is in flight.
- Generates byte enables with store-lane steering, aligns and sign/zero-extends loads, and presents a registered MEM/WB result.
- Parametrised in data width, address width and timeout depth.

Parameters:
- DATA_W, 32, data bus width; 32 or 64 only.
- ADDR_W, 32, byte address width.
- TIMEOUT, 15, maximum wait cycles for MACK before abort; >=1.
- LB, $clog2(DATA_W/8), derived localparam: byte-lane index bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX result valid.
- in_mreq  in  1  op is a memory access.
- in_write  in  1  1=store, 0=load.
- in_size  in  2  00=byte, 01=half, 10=word, 11=dword (11 legal only when DATA_W=64).
- in_unsigned  in  1  zero-extend load when 1.
- in_addr  in  ADDR_W  effective address (ALU result).
- in_wdata  in  DATA_W  store data, right-justified.
- in_bypass  in  DATA_W  non-memory result.
- in_rd  in  5  destination register.
- in_regwrite  in  1  destination write enable.
- stall_o  out  1  upstream must hold in_*.
- MREQ  out  1  memory request.
- WRITE  out  1  request is a store.
- SIZE  out  2  registered in_size.
- BE  out  DATA_W/8  byte enables.
- DAD  out  ADDR_W  lane-aligned address, low LB bits zero.
- DDT_O  out  DATA_W  store data, lane-steered.
- DDT_I  in  DATA_W  load data.
- MACK  in  1  memory acknowledge, one cycle per access.
- wb_valid  out  1  WB result valid (single-cycle pulse).
- wb_data  out  DATA_W  WB data.
- wb_rd  out  5  WB destination register.
- wb_regwrite  out  1  WB write enable.
- wb_err  out  1  access aborted.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; wait counter=0.
  - MREQ, WRITE, BE, wb_valid, wb_regwrite and wb_err =0.
  - SIZE, DAD, DDT_O, wb_data and wb_rd =0.
  - Reset asserted mid-access drops MREQ immediately; the in-flight op is lost with no wb_valid.
- FSM has two states, IDLE and ACCESS.
- IDLE: stall_o=0.
  - in_valid=1, in_mreq=0: capture bypass/rd/regwrite; wb_valid=1 next cycle. Latency 1.
  - in_valid=1, in_mreq=1: register the request. MREQ=1 from the next cycle; go to ACCESS with counter=0.
  - in_valid=0: wb_valid=0.
- ACCESS: stall_o=1 in every cycle, including the MACK cycle; in_* are ignored.
  - MACK=1: drop MREQ next edge; wb_valid=1 next cycle; go to IDLE.
    - Load: wb_data = extracted load data, wb_regwrite = captured regwrite.
    - Store: wb_regwrite=0.
  - MACK=0: counter++. When counter==TIMEOUT and MACK is still 0: abort, drop MREQ, wb_valid=1, wb_err=1, wb_regwrite=0, go to IDLE.
  - MACK and the timeout in the same cycle: MACK wins.
- Memory latency: accept at cycle N, MREQ high from N+1, MACK at M -> wb_valid at M+1. Minimum 2 cycles. Back-to-back memory ops have one idle bubble.
- Lane offset: off = in_addr[LB-1:0] with the low log2(size bytes) bits forced to 0 (misaligned accesses are truncated to natural alignment).
- BE: contiguous 2^size bits starting at lane off.
- DDT_O: in_wdata shifted left by off*8.
- Load extraction: (DDT_I >> off*8) masked to size.
  - in_unsigned=1: zero-extend.
  - in_unsigned=0: sign-extend from the top bit of the size.
  - A full-width access is passed unchanged.
- SIZE=11 with DATA_W=32 is treated as word.
- wb_valid is 0 in every cycle not listed above; wb_data/wb_rd hold their last value.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a memory op with in_addr & (2^size - 1) != 0 is not issued.
  - MREQ stays 0 and the state stays IDLE.
  - Next cycle: wb_valid=1, wb_err=1, wb_regwrite=0, wb_data = faulting address, zero-extended.
- Undefined: truncation to natural alignment as in Behaviour; wb_err is asserted only on timeout.

Test Plan:
- Reset: rst_n=0 while MREQ=1 in ACCESS -> MREQ=0 without waiting for a clock edge; no wb_valid after release.
- Load byte, signed: addr=0x1003, DDT_I=0x80FF_FF11, MACK 3 cycles after MREQ -> BE=4'b1000, DAD=0x1000, wb_data=0xFFFF_FF80, wb_valid 1 cycle after MACK, stall_o high for 4 cycles.
- Store half: addr=0x2002, wdata=0x0000_BEEF, MACK immediate -> BE=4'b1100, DDT_O=0xBEEF_0000, wb_regwrite=0.
- Timeout: TIMEOUT=4, MACK never asserted -> MREQ drops after 5 request cycles; wb_err=1, wb_regwrite=0.
- Non-mem op following a load: bypass=0x1234 held during stall -> accepted the cycle after the load's wb_valid; wb_data=0x1234 with 1-cycle latency.
- MEM_MISALIGN_TRAP_EN defined: word load at 0x3001 -> MREQ stays 0; wb_err=1, wb_data=0x3001. Undefined: same stimulus -> DAD=0x3000, BE=4'b1111.
